// File: rtl/int_receiver.sv
// Interrupt receiver: edge-detects request lines into pending bits, arbitrates
// one prioritised request to the CPU and runs the ACK/RETI handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request outstanding; arbitrates when IE=1 and pending
// REQ     | INTR asserted with VECTOR held; waits for INT_ACK or CLI
// SERVICE | CPU is in the ISR; IE saved, waits for RETI
module int_receiver #(
  parameter int NUM_SRC = 4,
  parameter int VEC_W   = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] INT_REQ,
  input  logic               SEI,
  input  logic               CLI,
  input  logic               INT_ACK,
  input  logic               RETI,
  output logic               INTR,
  output logic [VEC_W-1:0]   VECTOR,
  output logic               IE,
  output logic               IN_ISR,
  output logic [NUM_SRC-1:0] PENDING,
  output logic               OVERRUN
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] clr_mask;
  logic [VEC_W-1:0]   pri_idx;
  logic               saved_ie;
  logic               ie_strobe;
  logic               arb;
  logic               take_ack;
  logic               take_reti;

  always_comb begin
    edge_det  = INT_REQ & ~prev;
    // CLI wins over SEI when both strobe together
    ie_strobe = CLI ? 1'b0 : (SEI ? 1'b1 : IE);
  end

  // lowest index wins, so scan from the top down
  always_comb begin
    pri_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (PENDING[i]) pri_idx = VEC_W'(i);
    end
  end

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_mask[i] = take_ack && (VECTOR == VEC_W'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (arb) state_nxt = S_REQ;
      S_REQ: begin
        if (INT_ACK)  state_nxt = S_SERVICE;
        else if (CLI) state_nxt = S_IDLE;
      end
      S_SERVICE: if (RETI) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    INTR      = (state == S_REQ);
    IN_ISR    = (state == S_SERVICE);
    arb       = (state == S_IDLE) && IE && !CLI && (|PENDING);
    take_ack  = (state == S_REQ) && INT_ACK;
    take_reti = (state == S_SERVICE) && RETI;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev     <= '0;
      PENDING  <= '0;
      OVERRUN  <= 1'b0;
      IE       <= 1'b0;
      saved_ie <= 1'b0;
      VECTOR   <= '0;
    end else begin
      prev <= INT_REQ;
      // a new edge beats the acknowledge clear on the same bit
      PENDING <= (PENDING & ~clr_mask) | edge_det;
      if (|(edge_det & PENDING & ~clr_mask)) OVERRUN <= 1'b1;
      if (arb) VECTOR <= pri_idx;
      if (take_ack) begin
        saved_ie <= ie_strobe;
        IE       <= 1'b0;
      end else if (take_reti) begin
        IE <= saved_ie;
      end else begin
        IE <= ie_strobe;
      end
    end
  end

endmodule

// File: tb/tb_int_receiver.sv
// Directed bench for int_receiver: each step queues the expected output
// snapshot, clocks the DUT, then pops and compares it.
module tb_int_receiver;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] INT_REQ;
  logic       SEI, CLI, INT_ACK, RETI;
  logic       INTR, IE, IN_ISR, OVERRUN;
  logic [1:0] VECTOR;
  logic [3:0] PENDING;

  typedef struct packed {
    logic       intr;
    logic [1:0] vec;
    logic       ie;
    logic       isr;
    logic [3:0] pend;
    logic       ovr;
  } snap_t;

  snap_t sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  int_receiver #(.NUM_SRC(4), .VEC_W(2)) dut (
    .CLK(CLK), .RST(RST), .INT_REQ(INT_REQ), .SEI(SEI), .CLI(CLI),
    .INT_ACK(INT_ACK), .RETI(RETI), .INTR(INTR), .VECTOR(VECTOR), .IE(IE),
    .IN_ISR(IN_ISR), .PENDING(PENDING), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input string tag, input logic rst, input logic [3:0] req,
                     input logic sei, input logic cli, input logic ack,
                     input logic reti, input logic e_intr, input logic [1:0] e_vec,
                     input logic e_ie, input logic e_isr, input logic [3:0] e_pend,
                     input logic e_ovr);
    snap_t exp_s, obs_s;
    string t;
    RST = rst; INT_REQ = req; SEI = sei; CLI = cli; INT_ACK = ack; RETI = reti;
    exp_s = '{intr: e_intr, vec: e_vec, ie: e_ie, isr: e_isr, pend: e_pend, ovr: e_ovr};
    sb_q.push_back(exp_s);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    obs_s = '{intr: INTR, vec: VECTOR, ie: IE, isr: IN_ISR, pend: PENDING, ovr: OVERRUN};
    exp_s = sb_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs_s === exp_s) else begin
      errors++;
      $error("FAIL %s: observed intr=%b vec=%0d ie=%b isr=%b pend=%b ovr=%b expected intr=%b vec=%0d ie=%b isr=%b pend=%b ovr=%b",
             t, obs_s.intr, obs_s.vec, obs_s.ie, obs_s.isr, obs_s.pend, obs_s.ovr,
             exp_s.intr, exp_s.vec, exp_s.ie, exp_s.isr, exp_s.pend, exp_s.ovr);
    end
  endtask

  initial begin
    RST = 1'b1; INT_REQ = '0; SEI = 0; CLI = 0; INT_ACK = 0; RETI = 0;
    #2;
    //   tag              rst req     sei cli ack reti  intr vec ie isr pend    ovr
    cyc("reset",          1, 4'b0000, 0, 0, 0, 0,   0, 2'd0, 0, 0, 4'b0000, 0);
    // single event on source 2, then handshake
    cyc("sei",            0, 4'b0000, 1, 0, 0, 0,   0, 2'd0, 1, 0, 4'b0000, 0);
    cyc("edge2_pend",     0, 4'b0100, 0, 0, 0, 0,   0, 2'd0, 1, 0, 4'b0100, 0);
    cyc("edge2_intr",     0, 4'b0100, 0, 0, 0, 0,   1, 2'd2, 1, 0, 4'b0100, 0);
    cyc("req_hold1",      0, 4'b0100, 0, 0, 0, 0,   1, 2'd2, 1, 0, 4'b0100, 0);
    cyc("req_hold2",      0, 4'b0100, 0, 0, 0, 0,   1, 2'd2, 1, 0, 4'b0100, 0);
    cyc("ack2",           0, 4'b0100, 0, 0, 1, 0,   0, 2'd2, 0, 1, 4'b0000, 0);
    cyc("isr_level_held", 0, 4'b0100, 0, 0, 0, 0,   0, 2'd2, 0, 1, 4'b0000, 0);
    cyc("isr_req_low",    0, 4'b0000, 0, 0, 0, 0,   0, 2'd2, 0, 1, 4'b0000, 0);
    cyc("isr_edge0",      0, 4'b0001, 0, 0, 0, 0,   0, 2'd2, 0, 1, 4'b0001, 0);
    cyc("stray_ack_isr",  0, 4'b0001, 0, 0, 1, 0,   0, 2'd2, 0, 1, 4'b0001, 0);
    cyc("reti_restore",   0, 4'b0000, 0, 0, 0, 1,   0, 2'd2, 1, 0, 4'b0001, 0);
    cyc("rearb_vec0",     0, 4'b0000, 0, 0, 0, 0,   1, 2'd0, 1, 0, 4'b0001, 0);
    cyc("ack0",           0, 4'b0000, 0, 0, 1, 0,   0, 2'd0, 0, 1, 4'b0000, 0);
    cyc("reti0",          0, 4'b0000, 0, 0, 0, 1,   0, 2'd0, 1, 0, 4'b0000, 0);
    cyc("idle_quiet",     0, 4'b0000, 0, 0, 0, 0,   0, 2'd0, 1, 0, 4'b0000, 0);
    // masking
    cyc("sei_cli_both",   0, 4'b0000, 1, 1, 0, 0,   0, 2'd0, 0, 0, 4'b0000, 0);
    cyc("mask_edges13",   0, 4'b1010, 0, 0, 0, 0,   0, 2'd0, 0, 0, 4'b1010, 0);
    cyc("mask_no_intr",   0, 4'b0000, 0, 0, 0, 0,   0, 2'd0, 0, 0, 4'b1010, 0);
    cyc("mask_sei",       0, 4'b0000, 1, 0, 0, 0,   0, 2'd0, 1, 0, 4'b1010, 0);
    cyc("unmask_vec1",    0, 4'b0000, 0, 0, 0, 0,   1, 2'd1, 1, 0, 4'b1010, 0);
    cyc("cli_in_req",     0, 4'b0000, 0, 1, 0, 0,   0, 2'd1, 0, 0, 4'b1010, 0);
    cyc("cli_idle",       0, 4'b0000, 0, 0, 0, 0,   0, 2'd1, 0, 0, 4'b1010, 0);
    // edge on the requested source in the same cycle as its ACK
    cyc("coll_sei",       0, 4'b0000, 1, 0, 0, 0,   0, 2'd1, 1, 0, 4'b1010, 0);
    cyc("coll_req",       0, 4'b0000, 0, 0, 0, 0,   1, 2'd1, 1, 0, 4'b1010, 0);
    cyc("coll_ack_edge",  0, 4'b0010, 0, 0, 1, 0,   0, 2'd1, 0, 1, 4'b1010, 0);
    cyc("coll_reti",      0, 4'b0000, 0, 0, 0, 1,   0, 2'd1, 1, 0, 4'b1010, 0);
    // ACK and CLI together: saved IE captures 0
    cyc("ackcli_req",     0, 4'b0000, 0, 0, 0, 0,   1, 2'd1, 1, 0, 4'b1010, 0);
    cyc("ackcli_both",    0, 4'b0000, 0, 1, 1, 0,   0, 2'd1, 0, 1, 4'b1000, 0);
    cyc("ackcli_reti",    0, 4'b0000, 0, 0, 0, 1,   0, 2'd1, 0, 0, 4'b1000, 0);
    cyc("ackcli_idle",    0, 4'b0000, 0, 0, 0, 0,   0, 2'd1, 0, 0, 4'b1000, 0);
    // overrun: second edge on source 3 while still pending
    cyc("overrun_edge3",  0, 4'b1000, 0, 0, 0, 0,   0, 2'd1, 0, 0, 4'b1000, 1);
    cyc("overrun_sticky", 0, 4'b0000, 0, 0, 0, 0,   0, 2'd1, 0, 0, 4'b1000, 1);
    cyc("stray_reti_idle",0, 4'b0000, 0, 0, 0, 1,   0, 2'd1, 0, 0, 4'b1000, 1);
    // reset in the middle of an ISR with PENDING=0110
    cyc("pre_rst_sei",    0, 4'b0000, 1, 0, 0, 0,   0, 2'd1, 1, 0, 4'b1000, 1);
    cyc("pre_rst_req3",   0, 4'b0000, 0, 0, 0, 0,   1, 2'd3, 1, 0, 4'b1000, 1);
    cyc("pre_rst_ack3",   0, 4'b0000, 0, 0, 1, 0,   0, 2'd3, 0, 1, 4'b0000, 1);
    cyc("pre_rst_pend",   0, 4'b0110, 0, 0, 0, 0,   0, 2'd3, 0, 1, 4'b0110, 1);
    cyc("rst_mid_isr",    1, 4'b0110, 0, 0, 0, 0,   0, 2'd0, 0, 0, 4'b0000, 0);
    cyc("post_rst_edge",  0, 4'b0110, 0, 0, 0, 0,   0, 2'd0, 0, 0, 4'b0110, 0);
    cyc("post_rst_held",  0, 4'b0110, 0, 0, 0, 0,   0, 2'd0, 0, 0, 4'b0110, 0);
    cyc("post_rst_low",   0, 4'b0000, 0, 0, 0, 0,   0, 2'd0, 0, 0, 4'b0110, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
